wavetable_reader: RTL and testbench
===================================

# wavetable_reader

Upstream feeder for the `lerp` interpolator in the oscillator path. Each `sample_tick` advances a phase accumulator, fetches the two adjacent wavetable samples bracketing the current phase from a synchronous table memory, and presents them to `lerp` together with the fractional position as `ratio`, so the interpolator outputs `table[i]*(1-f) + table[i+1]*f`.

## Interface

- `SAMPLE_BITS`, 16, wavetable sample width; equals `lerp` `INPUT_BITS`.
- `TABLE_ADDR_BITS`, 8, log2 of table length.
- `RATIO_FRAC_BITS`, 8, fraction width; equals `lerp` `RATIO_FRAC_BITS`.
- `PHASE_BITS`, 24, accumulator width; must be ≥ `TABLE_ADDR_BITS + RATIO_FRAC_BITS`.

- `clk`  in  1  sole clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sample_tick`  in  1  one-cycle strobe requesting one output sample.
- `increment`  in  PHASE_BITS  phase step, sampled on an accepted or dropped tick.
- `phase_reset`  in  1  synchronous; zeroes the accumulator.
- `tbl_addr`  out  TABLE_ADDR_BITS  registered table read address.
- `tbl_rd`  out  1  registered read enable.
- `tbl_data`  in  SAMPLE_BITS  table read data, valid one cycle after the edge that sampled `tbl_addr`/`tbl_rd`.
- `ina`  out  SAMPLE_BITS  `table[idx+1]` to `lerp.ina`.
- `inb`  out  SAMPLE_BITS  `table[idx]` to `lerp.inb`.
- `ratio`  out  RATIO_FRAC_BITS  fractional position to `lerp.ratio`.
- `out_valid`  out  1  one-cycle pulse when `ina`/`inb`/`ratio` update.
- `busy`  out  1  high while a fetch is in progress (state ≠ IDLE).
- `overrun`  out  1  sticky; set when a tick arrives while busy.

## Operation

- `idx = phase[PHASE_BITS-1 -: TABLE_ADDR_BITS]`; `frac` = the next `RATIO_FRAC_BITS` bits below it. Lower bits are carried only for pitch accuracy.
- FSM states: IDLE, RD0, RD1.
  - IDLE + `sample_tick`: latch `idx`, `frac`; set `phase <= phase + increment` (mod 2^PHASE_BITS); set `tbl_addr <= idx`, `tbl_rd <= 1`; go to RD0.
  - RD0: `tbl_addr <= idx+1` (mod 2^TABLE_ADDR_BITS, so last entry wraps to 0); go to RD1.
  - RD1: capture `tbl_data` (=`table[idx]`) into internal stage register; `tbl_rd <= 0`; go to CAP phase at next edge, which returns to IDLE. On that edge: `inb <= stage`, `ina <= tbl_data`, `ratio <= frac_latched`, `out_valid <= 1`.
- `ina`, `inb` and `ratio` update only together on the `out_valid` edge and otherwise hold. The combinational `lerp` therefore never sees a mixed pair.
- Tick while busy: the read is dropped and `overrun <= 1` (sticky until reset). The phase still advances by `increment`, so pitch is preserved.
- `phase_reset`: `phase <= 0`. If it coincides with an IDLE tick, the tick uses phase 0 and `phase <= increment`.
- Reset (any time, including mid-fetch): FSM to IDLE immediately. `phase`, `tbl_addr`, `tbl_rd`, `ina`, `inb`, `ratio`, `out_valid`, `overrun` and the stage register all go to 0. An aborted fetch produces no `out_valid`.

## Timing

- Tick sampled at edge E0. `tbl_addr = idx` during E0–E1, `idx+1` during E1–E2.
- Stage register captures at E2. Outputs update and `out_valid` goes high at E3, low at E4.
- Latency is 3 clocks from tick edge to `out_valid`.
- `busy` is high E0–E3. A tick sampled at E3 is accepted, so the minimum tick spacing is 3 clocks.
- `tbl_rd` is high E0–E2.

## Test plan

Bench table: `table[i] = i<<8`, 1-cycle-latency model. Default parameters throughout.

- Reset, `increment=0x018000`, two ticks 10 cycles apart. First: `inb=0x0000`, `ina=0x0100`, `ratio=0x00`, `out_valid` exactly 3 edges after tick. Second: `inb=0x0100`, `ina=0x0200`, `ratio=0x80`.
- `phase_reset`, `increment=0xFF4000`, two ticks. Second yields `inb=0xFF00`, `ina=0x0000` (address wrap), `ratio=0x40`. Third tick uses phase `0xFE8000`: `inb=0xFE00`, `ina=0xFF00`, `ratio=0x80`.
- Ticks 1 cycle apart with `increment=0x010000`. Only one `out_valid` occurs and `overrun=1`. The next accepted tick reads `idx=2`.
- Ticks exactly 3 cycles apart, 8 times. Expect 8 `out_valid` pulses, `overrun=0`, `tbl_rd` never asserted twice for the same slot.
- Assert `reset_n=0` during RD1. Expect no `out_valid`, all outputs 0. The next tick after release reads `idx=0`.
- `phase_reset` coincident with tick, `increment=0x020000`. Expect `inb=0x0000`, `ratio=0x00`. The next tick reads `idx=2`.

Source files
------------

// File: rtl/wavetable_reader_if.sv
// Wavetable memory bus: registered read address/enable out, read data back.
// master = reader side (drives tbl_addr/tbl_rd), slave = table memory side.
interface wavetable_reader_if #(
  parameter int ADDR_BITS   = 8,
  parameter int SAMPLE_BITS = 16
);
  logic [ADDR_BITS-1:0]   tbl_addr;
  logic                   tbl_rd;
  logic [SAMPLE_BITS-1:0] tbl_data;

  modport master (
    output tbl_addr,
    output tbl_rd,
    input  tbl_data
  );

  modport slave (
    input  tbl_addr,
    input  tbl_rd,
    output tbl_data
  );
endinterface

// File: rtl/wavetable_reader.sv
// Phase accumulator + two-read wavetable fetch feeding the lerp interpolator.
// Ports: clk, reset_n, sample_tick, increment, phase_reset, tbl (table bus),
//        ina/inb/ratio/out_valid to lerp, busy, overrun (sticky).
module wavetable_reader #(
  parameter int SAMPLE_BITS     = 16,
  parameter int TABLE_ADDR_BITS = 8,
  parameter int RATIO_FRAC_BITS = 8,
  parameter int PHASE_BITS      = 24
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sample_tick,
  input  logic [PHASE_BITS-1:0]      increment,
  input  logic                       phase_reset,
  wavetable_reader_if.master         tbl,
  output logic [SAMPLE_BITS-1:0]     ina,
  output logic [SAMPLE_BITS-1:0]     inb,
  output logic [RATIO_FRAC_BITS-1:0] ratio,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       overrun
);

  localparam int TAB = TABLE_ADDR_BITS;
  localparam int RF  = RATIO_FRAC_BITS;

  typedef enum logic [1:0] {
    IDLE,
    RD0,
    RD1,
    CAP
  } state_t;

  state_t                  state;
  logic [PHASE_BITS-1:0]   phase;
  logic [TAB-1:0]          idx_q;
  logic [RF-1:0]           frac_q;
  logic [SAMPLE_BITS-1:0]  stage;

  logic                    accept;
  logic [PHASE_BITS-1:0]   phase_base;
  logic [TAB-1:0]          cur_idx;
  logic [RF-1:0]           cur_frac;

  // CAP only writes the lerp outputs, so it can overlap with a new fetch.
  assign accept     = sample_tick && (state == IDLE || state == CAP);
  assign phase_base = phase_reset ? '0 : phase;
  assign cur_idx    = phase_base[PHASE_BITS-1 -: TAB];
  assign cur_frac   = phase_base[PHASE_BITS-TAB-1 -: RF];
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      phase        <= '0;
      idx_q        <= '0;
      frac_q       <= '0;
      stage        <= '0;
      tbl.tbl_addr <= '0;
      tbl.tbl_rd   <= 1'b0;
      ina          <= '0;
      inb          <= '0;
      ratio        <= '0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      // Dropped ticks still advance phase to keep pitch.
      phase <= sample_tick ? phase_base + increment : phase_base;
      if (sample_tick && !accept) begin
        overrun <= 1'b1;
      end

      unique case (state)
        IDLE: begin
        end
        RD0: begin
          tbl.tbl_addr <= idx_q + 1'b1;
          state        <= RD1;
        end
        RD1: begin
          stage      <= tbl.tbl_data;
          tbl.tbl_rd <= 1'b0;
          state      <= CAP;
        end
        CAP: begin
          inb       <= stage;
          ina       <= tbl.tbl_data;
          ratio     <= frac_q;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        idx_q        <= cur_idx;
        frac_q       <= cur_frac;
        tbl.tbl_addr <= cur_idx;
        tbl.tbl_rd   <= 1'b1;
        state        <= RD0;
      end
    end
  end

endmodule

// File: tb/tb_wavetable_reader.sv
// Directed bench for wavetable_reader with a table[i] = i<<8 memory model.
// Checks are immediate assertions; summary prints passed/total.
module tb_wavetable_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_tick = 1'b0;
  logic [23:0] increment = '0;
  logic        phase_reset = 1'b0;
  logic [15:0] ina;
  logic [15:0] inb;
  logic [7:0]  ratio;
  logic        out_valid;
  logic        busy;
  logic        overrun;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int pulses = 0;
  int rd_cycles = 0;
  int p0;
  int r0;

  wavetable_reader_if #(.ADDR_BITS(8), .SAMPLE_BITS(16)) bus ();

  wavetable_reader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sample_tick(sample_tick),
    .increment  (increment),
    .phase_reset(phase_reset),
    .tbl        (bus.master),
    .ina        (ina),
    .inb        (inb),
    .ratio      (ratio),
    .out_valid  (out_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.tbl_rd) bus.tbl_data <= {bus.tbl_addr, 8'h00};
  end

  always @(negedge clk) begin
    if (out_valid) pulses <= pulses + 1;
    if (bus.tbl_rd) rd_cycles <= rd_cycles + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Tick (optionally with phase_reset) and follow the fetch to out_valid.
  task automatic tick_check(input string tag, input logic pr,
                            input logic [7:0] idx, input logic [15:0] e_inb,
                            input logic [15:0] e_ina, input logic [7:0] e_rat);
    logic [7:0] nxt;
    nxt = idx + 8'd1;
    @(negedge clk);
    sample_tick = 1'b1;
    phase_reset = pr;
    @(negedge clk);
    sample_tick = 1'b0;
    phase_reset = 1'b0;
    chk({tag, " addr0"}, 32'(bus.tbl_addr), 32'(idx));
    chk({tag, " rd0"}, 32'(bus.tbl_rd), 32'd1);
    chk({tag, " busy0"}, 32'(busy), 32'd1);
    @(negedge clk);
    chk({tag, " addr1"}, 32'(bus.tbl_addr), 32'(nxt));
    @(negedge clk);
    chk({tag, " rd2"}, 32'(bus.tbl_rd), 32'd0);
    chk({tag, " ov_early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, " ov"}, 32'(out_valid), 32'd1);
    chk({tag, " inb"}, 32'(inb), 32'(e_inb));
    chk({tag, " ina"}, 32'(ina), 32'(e_ina));
    chk({tag, " ratio"}, 32'(ratio), 32'(e_rat));
    chk({tag, " idle"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, " ov_low"}, 32'(out_valid), 32'd0);
    chk({tag, " ina_hold"}, 32'(ina), 32'(e_ina));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst ov", 32'(out_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst rd", 32'(bus.tbl_rd), 32'd0);
    chk("rst ina", 32'(ina), 32'd0);
    reset_n = 1'b1;

    // Basic fractional stepping.
    increment = 24'h018000;
    tick_check("t1a", 1'b0, 8'h00, 16'h0000, 16'h0100, 8'h00);
    repeat (5) @(negedge clk);
    tick_check("t1b", 1'b0, 8'h01, 16'h0100, 16'h0200, 8'h80);

    // Address wrap at the table end.
    @(negedge clk);
    phase_reset = 1'b1;
    @(negedge clk);
    phase_reset = 1'b0;
    increment = 24'hFF4000;
    tick_check("t2a", 1'b0, 8'h00, 16'h0000, 16'h0100, 8'h00);
    tick_check("t2b", 1'b0, 8'hFF, 16'hFF00, 16'h0000, 8'h40);
    tick_check("t2c", 1'b0, 8'hFE, 16'hFE00, 16'hFF00, 8'h80);

    // Back-to-back ticks: second is dropped but phase advances.
    @(negedge clk);
    phase_reset = 1'b1;
    @(negedge clk);
    phase_reset = 1'b0;
    increment = 24'h010000;
    p0 = pulses;
    sample_tick = 1'b1;
    repeat (2) @(negedge clk);
    sample_tick = 1'b0;
    repeat (6) @(negedge clk);
    chk("t3 pulses", 32'(pulses - p0), 32'd1);
    chk("t3 overrun", 32'(overrun), 32'd1);
    tick_check("t3n", 1'b0, 8'h02, 16'h0200, 16'h0300, 8'h00);
    chk("t3 sticky", 32'(overrun), 32'd1);

    // Minimum tick spacing of 3 clocks, no overrun.
    reset_n = 1'b0;
    @(negedge clk);
    chk("t4 ovr_clr", 32'(overrun), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    p0 = pulses;
    r0 = rd_cycles;
    for (int i = 0; i < 8; i++) begin
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("t4 pulses", 32'(pulses - p0), 32'd8);
    chk("t4 rd", 32'(rd_cycles - r0), 32'd16);
    chk("t4 overrun", 32'(overrun), 32'd0);
    chk("t4 inb", 32'(inb), 32'h0700);
    chk("t4 ina", 32'(ina), 32'h0800);

    // Reset in RD1 aborts the fetch.
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    p0 = pulses;
    reset_n = 1'b0;
    #1;
    chk("t5 busy", 32'(busy), 32'd0);
    chk("t5 ina", 32'(ina), 32'd0);
    chk("t5 inb", 32'(inb), 32'd0);
    chk("t5 ratio", 32'(ratio), 32'd0);
    chk("t5 addr", 32'(bus.tbl_addr), 32'd0);
    chk("t5 rd", 32'(bus.tbl_rd), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5 no_ov", 32'(pulses - p0), 32'd0);
    tick_check("t5n", 1'b0, 8'h00, 16'h0000, 16'h0100, 8'h00);

    // phase_reset coincident with a tick.
    increment = 24'h020000;
    tick_check("t6a", 1'b1, 8'h00, 16'h0000, 16'h0100, 8'h00);
    tick_check("t6b", 1'b0, 8'h02, 16'h0200, 16'h0300, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
